// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite line fetcher.
// Slot count, sprite height and ROM address width are fixed here for the whole slice.
package sprite_pkg;

   localparam int NUM_SPRITES = 4;
   localparam int SPRITE_H    = 32;
   localparam int ROM_AW      = 7;

   typedef struct packed {
      logic              en;
      logic [9:0]        x;
      logic [9:0]        y;
      logic [ROM_AW-1:0] base;
   } sprite_attr_t;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      WAIT,
      CAPTURE,
      COMMIT
   } fetch_state_t;

endpackage

// File: rtl/sprite_hit_check.sv
// Combinational vertical hit test for one sprite slot against a target line.
// The bottom edge is formed at 11 bits so y near 1023 cannot wrap into a false hit.
module sprite_hit_check
   import sprite_pkg::*;
(
   input  sprite_attr_t i_attr,
   input  logic [9:0]   i_line,
   output logic         o_hit,
   output logic [9:0]   o_row_offset
);

   logic [10:0] w_line_ext;
   logic [10:0] w_y_end;
   logic        w_unused_x;

   assign w_line_ext   = {1'b0, i_line};
   assign w_y_end      = {1'b0, i_attr.y} + 11'(SPRITE_H);
   assign o_row_offset = i_line - i_attr.y;
   assign o_hit        = i_attr.en && (i_line >= i_attr.y) && (w_line_ext < w_y_end);

   // Horizontal position plays no part in the vertical test.
   assign w_unused_x   = ^i_attr.x;

endmodule

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite row fetcher: scans shadowed attributes during hblank, reads one
// ROM row per visible slot, then commits every slot's row to the line registers together.
module sprite_line_fetcher
   import sprite_pkg::*;
#(
   parameter int ROM_LAT = 1
)(
   input  logic                               Clk,
   input  logic                               Reset,
   input  logic                               frame_start,
   input  logic                               line_start,
   input  logic [9:0]                         next_line,
   input  logic [NUM_SPRITES-1:0]             spr_en,
   input  logic [NUM_SPRITES-1:0][9:0]        spr_x,
   input  logic [NUM_SPRITES-1:0][9:0]        spr_y,
   input  logic [NUM_SPRITES-1:0][ROM_AW-1:0] spr_base,
   output logic [ROM_AW-1:0]                  rom_addr,
   input  logic [31:0]                        rom_data,
   output logic [NUM_SPRITES-1:0][31:0]       row_data,
   output logic [NUM_SPRITES-1:0][9:0]        row_x,
   output logic [NUM_SPRITES-1:0]             row_valid,
   output logic                               busy,
   output logic                               done,
   output logic                               overrun
);

   localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SPRITES - 1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(ROM_LAT - 1);

   fetch_state_t                       r_state;
   logic [IDX_W-1:0]                   r_idx;
   logic [WAIT_W-1:0]                  r_wait_cnt;
   logic [9:0]                         r_line;
   sprite_attr_t [NUM_SPRITES-1:0]     r_shadow;
   logic [NUM_SPRITES-1:0][31:0]       r_stage_data;
   logic [NUM_SPRITES-1:0][9:0]        r_stage_x;
   logic [NUM_SPRITES-1:0]             r_stage_valid;
   logic [ROM_AW-1:0]                  r_rom_addr;
   logic [NUM_SPRITES-1:0][31:0]       r_row_data;
   logic [NUM_SPRITES-1:0][9:0]        r_row_x;
   logic [NUM_SPRITES-1:0]             r_row_valid;
   logic                               r_busy;
   logic                               r_done;
   logic                               r_overrun;

   sprite_attr_t [NUM_SPRITES-1:0]     w_attr_in;
   sprite_attr_t                       w_cur_attr;
   logic                               w_hit;
   logic [9:0]                         w_row_offset;
   logic [ROM_AW-1:0]                  w_hit_addr;
   logic                               w_unused_offset;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_attr
         assign w_attr_in[gi] = '{en: spr_en[gi], x: spr_x[gi], y: spr_y[gi], base: spr_base[gi]};
      end
   endgenerate

   assign w_cur_attr = r_shadow[r_idx];

   sprite_hit_check u_hit_check (
      .i_attr       (w_cur_attr),
      .i_line       (r_line),
      .o_hit        (w_hit),
      .o_row_offset (w_row_offset)
   );

   // Row address wraps modulo the ROM size; offsets never exceed SPRITE_H-1 anyway.
   assign w_hit_addr      = w_cur_attr.base + w_row_offset[ROM_AW-1:0];
   assign w_unused_offset = ^w_row_offset[9:ROM_AW];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_shadow <= '0;
      end else if (frame_start) begin
         r_shadow <= w_attr_in;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state       <= IDLE;
         r_idx         <= '0;
         r_wait_cnt    <= '0;
         r_line        <= '0;
         r_stage_data  <= '0;
         r_stage_x     <= '0;
         r_stage_valid <= '0;
         r_rom_addr    <= '0;
         r_row_data    <= '0;
         r_row_x       <= '0;
         r_row_valid   <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (frame_start) begin
            r_overrun <= 1'b0;
         end
         // A late line_start is dropped; flagging it wins over a same-cycle clear.
         if (line_start && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (line_start) begin
                  r_line        <= next_line;
                  r_idx         <= '0;
                  r_stage_valid <= '0;
                  r_busy        <= 1'b1;
                  r_state       <= SCAN;
               end
            end

            SCAN: begin
               if (w_hit) begin
                  r_rom_addr <= w_hit_addr;
                  r_wait_cnt <= WAIT_INIT;
                  r_state    <= WAIT;
               end else begin
                  r_stage_valid[r_idx] <= 1'b0;
                  r_stage_data[r_idx]  <= '0;
                  r_stage_x[r_idx]     <= '0;
                  if (r_idx == LAST_IDX) begin
                     r_state <= COMMIT;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end

            WAIT: begin
               if (r_wait_cnt == '0) begin
                  r_state <= CAPTURE;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 1'b1;
               end
            end

            CAPTURE: begin
               r_stage_data[r_idx]  <= rom_data;
               r_stage_x[r_idx]     <= w_cur_attr.x;
               r_stage_valid[r_idx] <= 1'b1;
               if (r_idx == LAST_IDX) begin
                  r_state <= COMMIT;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= SCAN;
               end
            end

            COMMIT: begin
               r_row_data  <= r_stage_data;
               r_row_x     <= r_stage_x;
               r_row_valid <= r_stage_valid;
               r_done      <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign rom_addr  = r_rom_addr;
   assign row_data  = r_row_data;
   assign row_x     = r_row_x;
   assign row_valid = r_row_valid;
   assign busy      = r_busy;
   assign done      = r_done;
   assign overrun   = r_overrun;

endmodule
